// File: rtl/des_ip_loader.sv
// Byte-serial DES input loader: assembles 8 bytes, applies the initial permutation and
// hands L0/R0 plus the block mode to the round engine through a double-buffered stream.
module des_ip_loader #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_byte,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_l,
    output logic [31:0]        out_r,
    output logic               out_mode,
    output logic [COUNT_W-1:0] blk_count
);

    logic [2:0]         cnt_q, cnt_d;
    logic [63:0]        asm_q, asm_d;
    logic               asm_mode_q, asm_mode_d;
    logic               asm_full_q, asm_full_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_l_q, out_l_d;
    logic [31:0]        out_r_q, out_r_d;
    logic               out_mode_q, out_mode_d;
    logic [COUNT_W-1:0] blk_count_q, blk_count_d;

    logic [7:0]  byte_rev;
    logic [63:0] raw_cur;
    logic [63:0] ip_new;
    logic [63:0] ip_asm;
    logic        blk_mode;
    logic        accept;
    logic        handoff;

    // raw[0] is DES bit 1; ip[8r+c] takes raw[IP-1] from the row-major IP table.
    function automatic logic [63:0] des_ip(input logic [63:0] raw);
        logic [63:0] ip;
        int          src;
        ip = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r < 4) src = 57 + 2 * r - 8 * c;
                else       src = 56 + 2 * (r - 4) - 8 * c;
                ip[6'(8 * r + c)] = raw[6'(src)];
            end
        end
        return ip;
    endfunction

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            byte_rev[j] = in_byte[7 - j];
        end
        raw_cur = asm_q;
        raw_cur[{cnt_q, 3'b000} +: 8] = byte_rev;
        blk_mode = (cnt_q == 3'd0) ? in_mode : asm_mode_q;
        ip_new   = des_ip(raw_cur);
        ip_asm   = des_ip(asm_q);
    end

    assign in_ready = !asm_full_q;
    assign accept   = in_valid && !asm_full_q;
    assign handoff  = out_valid_q && out_ready;

    always_comb begin
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        asm_mode_d  = asm_mode_q;
        asm_full_d  = asm_full_q;
        out_valid_d = out_valid_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_mode_d  = out_mode_q;
        blk_count_d = blk_count_q;

        if (flush) begin
            cnt_d       = 3'd0;
            asm_full_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (handoff) begin
                blk_count_d = blk_count_q + COUNT_W'(1);
                if (asm_full_q) begin
                    out_l_d    = ip_asm[31:0];
                    out_r_d    = ip_asm[63:32];
                    out_mode_d = asm_mode_q;
                    asm_full_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            // accept and an assembly drain are exclusive: accept needs asm_full_q low
            if (accept) begin
                asm_d = raw_cur;
                if (cnt_q == 3'd0) asm_mode_d = in_mode;
                if (cnt_q == 3'd7) begin
                    cnt_d = 3'd0;
                    if (!out_valid_q || handoff) begin
                        out_l_d     = ip_new[31:0];
                        out_r_d     = ip_new[63:32];
                        out_mode_d  = blk_mode;
                        out_valid_d = 1'b1;
                    end else begin
                        asm_full_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 3'd0;
            asm_q       <= '0;
            asm_mode_q  <= 1'b0;
            asm_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_mode_q  <= 1'b0;
            blk_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            asm_mode_q  <= asm_mode_d;
            asm_full_q  <= asm_full_d;
            out_valid_q <= out_valid_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_mode_q  <= out_mode_d;
            blk_count_q <= blk_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_mode  = out_mode_q;
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_des_ip_loader.sv
// Bench for des_ip_loader: directed and random byte streams scored against a table-driven
// DES IP model with a queue of completed-but-undelivered blocks.
module tb_des_ip_loader;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_byte;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_l;
    logic [31:0]   out_r;
    logic          out_mode;
    logic [CW-1:0] blk_count;

    des_ip_loader #(.COUNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_mode  (out_mode),
        .blk_count (blk_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        m;
        logic [31:0] r;
        logic [31:0] l;
    } blk_t;

    int ip_tab [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    int         checks = 0;
    int         failures = 0;
    int         hs_cnt = 0;
    logic [7:0] part [$];
    logic       part_mode;
    blk_t       exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Block bytes given big-endian: blk[63] is DES bit 1 (MSB of byte 0).
    function automatic blk_t ref_ip(input logic [63:0] blk, input logic m);
        logic [63:0] ipb;
        blk_t        res;
        for (int n = 0; n < 64; n++) ipb[n] = blk[6'(64 - ip_tab[n])];
        res.l = ipb[31:0];
        res.r = ipb[63:32];
        res.m = m;
        return res;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[i] = v[31 - i];
        return o;
    endfunction

    // Called at a negedge with inputs already driven; advances one clock.
    task automatic tick();
        logic        acc, hand, hold;
        logic [64:0] snap;
        blk_t        e;
        logic [63:0] raw;
        acc  = in_valid && in_ready;
        hand = out_valid && out_ready;
        hold = out_valid && !out_ready && !flush;
        snap = {out_mode, out_r, out_l};
        if (flush) begin
            part.delete();
            exp_q.delete();
        end else begin
            if (hand) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_block", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_l", 64'(out_l), 64'(e.l));
                    chk("out_r", 64'(out_r), 64'(e.r));
                    chk("out_mode", 64'(out_mode), 64'(e.m));
                end
                hs_cnt++;
            end
            if (acc) begin
                if (part.size() == 0) part_mode = in_mode;
                part.push_back(in_byte);
                if (part.size() == 8) begin
                    for (int k = 0; k < 8; k++) raw[63 - 8 * k -: 8] = part[k];
                    exp_q.push_back(ref_ip(raw, part_mode));
                    part.delete();
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("blk_count", 64'(blk_count), 64'(hs_cnt % (1 << CW)));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        if (hold) chk("stable", {63'd0, 1'b0} | 64'(snap != {out_mode, out_r, out_l}), 64'(0));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic m);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_mode  = m;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("send_timeout", 64'(in_ready), 64'(1));
        else tick();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] blk, input logic m, input logic toggle);
        logic [2:0] k3;
        for (int k = 0; k < 8; k++) begin
            k3 = 3'(k);
            send_byte(blk[63 - 8 * k -: 8], (k == 0 || !toggle) ? m : k3[0]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_l", 64'(out_l), 64'(0));
        chk("rst_out_r", 64'(out_r), 64'(0));
        chk("rst_out_mode", 64'(out_mode), 64'(0));
        chk("rst_blk_count", 64'(blk_count), 64'(0));
        part.delete();
        exp_q.delete();
        hs_cnt = 0;
        @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0]   std;
        logic [7:0]    bp [24];
        logic [CW-1:0] seq [5];
        logic [CW-1:0] saved;
        int            idx;
        logic          rdy;

        std = 64'h0123456789ABCDEF;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_mode = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Standard vector, sustained rate
        out_ready = 1'b1;
        send_block(std, 1'b0, 1'b0);
        chk("std_valid", 64'(out_valid), 64'(1));
        chk("std_l", 64'(rev32(out_l)), 64'h0000_0000_CC00_CCFF);
        chk("std_r", 64'(rev32(out_r)), 64'h0000_0000_F0AA_F0AA);
        tick();
        chk("std_count", 64'(blk_count), 64'(1));

        // Single-bit walk
        send_block(64'h8000_0000_0000_0000, 1'b0, 1'b0);
        chk("walk0_l", 64'(out_l), 64'(0));
        chk("walk0_r", 64'(out_r), 64'h80);
        send_block(64'h0000_0000_0000_0001, 1'b0, 1'b0);
        chk("walk7_l", 64'(out_l), 64'h0100_0000);
        chk("walk7_r", 64'(out_r), 64'(0));
        send_block(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        chk("ones", {out_r, out_l}, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        // Mode capture with in_mode toggling after byte 0
        send_block({$urandom, $urandom}, 1'b1, 1'b1);
        chk("mode_a", 64'(out_mode), 64'(1));
        send_block({$urandom, $urandom}, 1'b0, 1'b1);
        chk("mode_b", 64'(out_mode), 64'(0));
        drain();

        // Backpressure: two blocks buffered, third waits
        for (int i = 0; i < 24; i++) bp[i] = 8'($urandom);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_byte  = bp[idx];
            in_mode  = 1'b0;
            rdy = in_ready;
            tick();
            if (rdy) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'(16));
        chk("bp_stall", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_reopen", 64'(in_ready), 64'(1));
        chk("bp_next_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        while (idx < 24) begin
            send_byte(bp[idx], 1'b0);
            idx++;
        end
        drain();

        // Flush mid-block, then the standard vector
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h3C, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send_block(std, 1'b0, 1'b0);
        chk("flush_std_l", 64'(rev32(out_l)), 64'h0000_0000_CC00_CCFF);
        chk("flush_std_r", 64'(rev32(out_r)), 64'h0000_0000_F0AA_F0AA);
        drain();

        // Flush a held block with stalled output; count must not move
        out_ready = 1'b0;
        send_block({$urandom, $urandom}, 1'b1, 1'b0);
        saved = blk_count;
        flush = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_drop", 64'(out_valid), 64'(0));
        chk("flush_count", 64'(blk_count), 64'(saved));

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_byte   = 8'($urandom);
            in_mode   = 1'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 60) == 0);
            tick();
        end
        flush = 1'b1;
        in_valid = 1'b0;
        tick();
        flush = 1'b0;

        // Reset while a block is held and another is partly assembled
        out_ready = 1'b0;
        send_block({$urandom, $urandom}, 1'b1, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        do_reset();
        out_ready = 1'b1;
        send_block(std, 1'b0, 1'b0);
        chk("post_rst_l", 64'(rev32(out_l)), 64'h0000_0000_CC00_CCFF);
        chk("post_rst_r", 64'(rev32(out_r)), 64'h0000_0000_F0AA_F0AA);
        drain();

        // Counter wrap with a 2-bit counter
        do_reset();
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            send_block({$urandom, $urandom}, 1'(b), 1'b0);
            tick();
            chk("wrap_seq", 64'(blk_count), 64'(seq[b]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_ip_loader.md
# des_ip_loader

- Input-side front end of the DES datapath; the counterpart to the final-permutation stage on the output side.
- Accepts a 64-bit block one byte at a time over a valid/ready stream and applies the DES initial permutation (IP).
- Hands L0/R0 halves, plus the per-block encrypt/decrypt mode, to the round engine over a second valid/ready interface.
- Two block buffers (assembly plus output register), so byte intake of the next block overlaps with the round engine draining the current one.

## Interface
Parameters:
- COUNT_W, 8, width of the emitted-block counter (wraps modulo 2^COUNT_W).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: asynchronous assert, active-low.
- flush  input  1  synchronous clear: drops partial/held data; blk_count is preserved.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  loader can accept a byte.
- in_byte  input  8  data byte; the first byte of a block carries DES bits 1–8.
- in_mode  input  1  0 = encrypt, 1 = decrypt; sampled only with byte 0 of a block.
- out_valid  output  1  out_l/out_r/out_mode hold a permuted block.
- out_ready  input  1  round engine accepts the block.
- out_l  output  32  L0; out_l[i] = DES IP output bit i+1.
- out_r  output  32  R0; out_r[i] = DES IP output bit i+33.
- out_mode  output  1  mode captured with this block's byte 0.
- blk_count  output  COUNT_W  number of blocks handed off (out handshakes), wrapping.

## Operation
- Byte handshake: occurs on an edge with in_valid && in_ready.
- Byte mapping: byte k (0..7), bit b (7 = MSB) → raw[8k + 7 − b]. So raw[0] = DES bit 1, the MSB of the first byte.
- IP index formula, for 64-bit ip[8r+c] (r, c in 0..7):
  - ip[8r+c] = raw[IP−1].
  - IP = 58 + 2r − 8c for r < 4.
  - IP = 57 + 2(r−4) − 8c for r ≥ 4.
  - Equivalently, the standard DES IP table read row-major.
- Output halves: out_l = ip[31:0], out_r = ip[63:32].
- State:
  - byte counter cnt (0..7);
  - assembly buffer with asm_full flag and asm_mode;
  - output register with out_valid.
- Mode capture: on an accept with cnt = 0, in_mode is latched as the block mode.
- Accept with cnt < 7: byte is stored, cnt increments.
- Accept with cnt = 7 (block complete), cnt → 0, then:
  - if out_valid = 0, or out_valid && out_ready this edge: the permuted block (including this byte) loads into the output register and out_valid = 1;
  - otherwise: the raw block stays in assembly and asm_full = 1.
- in_ready = !asm_full. While asm_full, further bytes are refused.
- asm_full drain: on an edge with out_valid && out_ready && asm_full, the assembly block loads into the output register, out_valid stays 1, and asm_full → 0.
- Output handshake with no replacement block: out_valid → 0.
- Every output handshake increments blk_count (modulo 2^COUNT_W).
- Output stability: out_l/out_r/out_mode must not change while out_valid && !out_ready.
- flush = 1, at the next edge:
  - cnt → 0, asm_full → 0, out_valid → 0;
  - any in/out handshake in that same cycle is ignored;
  - blk_count is unchanged.
- Reset: all state cleared asynchronously, mid-block included. A partial block is discarded, and the first byte after reset is byte 0.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_l = 0, out_r = 0, out_mode = 0, blk_count = 0.
- Latency: out_valid rises on the edge that accepts byte 7 (visible in the following cycle). No combinational path from in_* to out_*.
- in_ready is a function of registered state only; out_ready does not combinationally affect in_ready.
- Throughput: 1 byte/cycle sustained when out_ready is held high, i.e. one block per 8 cycles with no bubbles.
- Backpressure with out_ready low: the loader accepts exactly 16 bytes (2 blocks), then in_ready = 0 until the first out handshake. in_ready returns to 1 the cycle after that handshake.
- Simultaneous cases:
  - byte-7 accept together with an out handshake → new block loads directly into the output register, asm_full stays 0;
  - flush together with rst_n low → reset wins.

## Test plan
- Standard vector, out_ready = 1:
  - stimulus: bytes 01 23 45 67 89 AB CD EF, mode = 0;
  - expected: out_l in DES order (index 0 = first hex MSB) = CC00CCFF and out_r = F0AAF0AA, one cycle after byte 7; blk_count = 1 after the handshake.
- Single-bit walk:
  - byte 0 = 80h, all others 00 → only out_r[7] = 1;
  - byte 7 = 01h, all others 00 → only out_l[24] = 1;
  - all FFh → all ones.
- Backpressure, out_ready = 0:
  - stream 3 blocks with in_valid always high → 16 bytes accepted, then in_ready = 0;
  - pulse out_ready for one cycle → block 1 handed off, block 2 appears on the next cycle, in_ready = 1;
  - the 3rd block completes intact.
- Mode capture: block A with mode 1 and block B with mode 0, with in_mode toggling on bytes 1–7 → out_mode = 1 then 0.
- Flush mid-block: flush after 3 bytes, then send the full standard vector → only the standard block is emitted, with correct values.
- Reset / wrap:
  - assert rst_n low mid-block and while out_valid = 1 → all outputs return to reset values immediately;
  - with COUNT_W = 2, 5 blocks → blk_count sequence 1, 2, 3, 0, 1.
